// File: rtl/usr_pkg.sv
// Shared mode encodings, FSM state codes and helpers for the universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Only the modes that move bits make sense as a one-bit-per-cycle burst.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
               (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational shift/rotate datapath; shared by the single-cycle and burst paths.
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] next_value
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    logic [CNT_W-1:0] rot;
    logic [WIDTH-1:0] fill_lo;
    logic [WIDTH-1:0] fill_hi;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] asr_v;
    logic [WIDTH-1:0] rotl_v;
    logic [WIDTH-1:0] rotr_v;

    // A shift by >= WIDTH yields zero and an all-ones fill mask, so clamping falls out naturally.
    always_comb begin
        rot     = amount % WIDTH_C;
        fill_lo = ~(ONES << amount);
        fill_hi = ~(ONES >> amount);
        shl_v   = (value << amount) | (fill_lo & {WIDTH{sin_r}});
        shr_v   = (value >> amount) | (fill_hi & {WIDTH{sin_l}});
        asr_v   = (value >> amount) | (fill_hi & {WIDTH{value[WIDTH-1]}});
        rotl_v  = (value << rot) | (value >> (WIDTH_C - rot));
        rotr_v  = (value >> rot) | (value << (WIDTH_C - rot));
    end

    always_comb begin
        next_value = value;
        case (mode)
            MODE_SHL:  next_value = shl_v;
            MODE_SHR:  next_value = shr_v;
            MODE_ROTL: next_value = rotl_v;
            MODE_ROTR: next_value = rotr_v;
            MODE_ASR:  next_value = asr_v;
            default:   next_value = value;
        endcase
    end

endmodule

// File: rtl/param_universal_shift_reg.sv
// Universal shift register with single-cycle ops and a one-bit-per-cycle burst mode.
//   state | meaning
//   IDLE  | accept start (burst) or en (single-cycle op)
//   RUN   | shift one bit per cycle with latched mode, cnt counts down
//   DONE  | one-cycle completion pulse, inputs ignored
module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       burst_mode;
    logic [2:0]       core_mode;
    logic [CNT_W-1:0] core_amt;
    logic [WIDTH-1:0] core_out;
    logic             start_ok;

    assign start_ok = (state == ST_IDLE) && start && is_burst_mode(mode);

    always_comb begin
        core_mode = mode;
        core_amt  = amt;
        if (state == ST_RUN) begin
            core_mode = burst_mode;
            core_amt  = CNT_W'(1);
        end
    end

    usr_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .value      (dataout),
        .mode       (core_mode),
        .amount     (core_amt),
        .sin_l      (sin_l),
        .sin_r      (sin_r),
        .next_value (core_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            burst_mode <= MODE_HOLD;
            dataout    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        burst_mode <= mode;
                        cnt        <= amt;
                        state      <= (amt != '0) ? ST_RUN : ST_DONE;
                    end else if (en) begin
                        dataout <= (mode == MODE_LOAD) ? datain : core_out;
                    end
                end
                ST_RUN: begin
                    dataout <= core_out;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign zero = (dataout == '0);

endmodule

// File: doc/param_universal_shift_reg.md
# param_universal_shift_reg

Parametrised universal shift register: a WIDTH-bit register supporting hold, load, logical/arithmetic shifts and rotates by a variable amount in one cycle. It adds a burst mode that shifts one bit per cycle for a programmed count, sampling the serial inputs each cycle, with a busy/done handshake. It serves as the general-purpose shift/serialiser element in datapaths and serial-link front ends.

## Interface
- WIDTH, 8: register width, ≥2.
- CNT_W, $clog2(WIDTH)+1: width of the amount/count field; must represent WIDTH.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  apply `mode` with `amt` this cycle (single-cycle op).
- start  in  1  launch a burst op.
- mode  in  3  000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROTL, 101 ROTR, 110 ASR, 111 reserved (HOLD).
- amt  in  CNT_W  shift/rotate amount, or burst length.
- sin_l  in  1  fill bit entering at the MSB end (SHR).
- sin_r  in  1  fill bit entering at the LSB end (SHL).
- datain  in  WIDTH  parallel load value.
- dataout  out  WIDTH  register contents.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- zero  out  1  dataout == 0, combinational from the register.

## Operation
- FSM states: IDLE, RUN, DONE. Internal down-counter `cnt` (CNT_W bits) and latched burst mode.
- IDLE, start=1, mode ∈ {SHL, SHR, ROTL, ROTR, ASR}:
  - Latch mode. Set cnt=amt.
  - amt≠0: go to RUN.
  - amt=0: go to DONE with no shift.
- IDLE, start=1 with any other mode: start is ignored, and `en` is evaluated normally.
- Priority: start over en when start is accepted.
- IDLE, en=1 (no accepted start), single-cycle op:
  - SHL by amt: vacated LSBs filled with sin_r.
  - SHR by amt: vacated MSBs filled with sin_l.
  - ASR by amt: vacated MSBs filled with the old MSB.
  - ROTL/ROTR by amt mod WIDTH.
  - LOAD: dataout ← datain.
  - HOLD and reserved: no change.
- Amount clamping: amt ≥ WIDTH on SHL/SHR gives all fill bits; on ASR gives all copies of the old MSB.
- RUN:
  - Each cycle, apply the latched mode by 1 bit. sin_l/sin_r are sampled that cycle.
  - cnt decrements each cycle.
  - When cnt==1, the shift occurs and the FSM goes to DONE.
  - en and start are ignored.
- DONE: done=1 for one cycle, then IDLE. start and en are ignored.
- Burst amt > WIDTH runs exactly amt cycles; the result matches clamping.
- Reset (async, reset=0): dataout=0, state IDLE, cnt=0, busy=0, done=0, zero=1. Reset takes effect immediately, including mid-burst; a partial burst is discarded.

## Timing
- Single-cycle op: inputs sampled at edge k; result on dataout after edge k.
- Burst accepted at edge k:
  - Shifts occur at edges k+1 … k+amt.
  - busy=1 for exactly amt cycles, starting after edge k.
  - done=1 during the cycle after edge k+amt, with busy=0.
  - Back to IDLE after edge k+amt+1.
- Burst amt=0: done=1 in the cycle after edge k; busy never asserts.
- busy = (state==RUN); done = (state==DONE); both registered-state decodes, glitch-free.
- Next start is accepted no earlier than the cycle after done.

## Structure
- Package usr_pkg: mode localparams/enum (MODE_HOLD … MODE_ASR), FSM state enum.
- Sub-module usr_shift_core: combinational. Inputs: value, mode, amount, sin_l, sin_r. Output: next value, with clamping and rotate modulo.
- Instantiated once and shared by both paths: single-cycle path uses amt; burst path uses amount=1 with the latched mode.
- Top holds the register, FSM and counter.

## Test plan
- Reset held low → dataout=00, busy=0, done=0, zero=1. Release, no en/start → values hold.
- en, LOAD datain=A5 → dataout=A5. Then en, ROTL amt=3 → 2D. Then en, ROTR amt=11 → 2D rotated right by 3 = A5.
- LOAD 90, then ASR amt=2 → E4. LOAD 90, then SHL amt=9 sin_r=1 → FF (clamp).
- LOAD 00, start SHL amt=8, sin_r stream 1,0,1,1,0,0,1,0 (one bit per shift cycle):
  - busy high exactly 8 cycles, then done for 1 cycle, dataout=B2.
  - en/start pulses during busy have no effect.
- start with amt=0 → done next cycle, busy never high, dataout unchanged. start with mode=LOAD → ignored as burst, en=1 loads datain.
- start SHR amt=6; after 3 shifts drive reset=0 → immediately dataout=00, busy=0, done=0. After release, a new burst completes normally.
